// File: rtl/pulse_window_counter_if.sv
// Handshake/bus bundle for pulse_window_counter.
// master: upstream requester + result consumer; slave: the counter itself.
interface pulse_window_counter_if #(
  parameter int COUNT_W = 8,
  parameter int WIN_W   = 16
);
  logic               pulse_in;
  logic               start;
  logic [WIN_W-1:0]   window_len;
  logic               busy;
  logic               cnt_valid;
  logic               cnt_ready;
  logic [COUNT_W-1:0] cnt_data;
  logic               overflow;

  modport master (
    output pulse_in, start, window_len, cnt_ready,
    input  busy, cnt_valid, cnt_data, overflow
  );

  modport slave (
    input  pulse_in, start, window_len, cnt_ready,
    output busy, cnt_valid, cnt_data, overflow
  );
endinterface

// File: rtl/pulse_window_counter.sv
// pulse_window_counter: counts pulse_in over a window of window_len clk
// edges following an accepted start, then offers the count on a
// valid/ready result port.
// Optional build macro PULSE_CNT_SATURATE_EN: count saturates at all-ones
// instead of wrapping; overflow is sticky in both builds.
module pulse_window_counter #(
  parameter int COUNT_W = 8,
  parameter int WIN_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pulse_window_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIN_W-1:0]   r_rem;
  logic [COUNT_W-1:0] r_cnt;
  logic               r_ovf;
  logic               r_busy;
  logic               r_valid;

  logic               w_cnt_max;
  logic [COUNT_W-1:0] w_cnt_next;
  logic               w_last_edge;

  // Next count value for a sampled pulse; all-ones is the overflow point.
  assign w_cnt_max = &r_cnt;
`ifdef PULSE_CNT_SATURATE_EN
  assign w_cnt_next = w_cnt_max ? r_cnt : r_cnt + 1'b1;
`else
  assign w_cnt_next = r_cnt + 1'b1;
`endif

  // The edge that sees one remaining cycle is the Nth (last) window edge.
  assign w_last_edge = (r_rem == {{(WIN_W-1){1'b0}}, 1'b1});

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // cnt_data/overflow keep the last result until a new start.
          if (bus.start) begin
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_busy <= 1'b1;
            r_rem  <= bus.window_len;
            if (bus.window_len == '0) begin
              r_state <= REPORT;
              r_valid <= 1'b1;
            end else begin
              r_state <= COUNT;
            end
          end
        end
        COUNT: begin
          // start is ignored here; window_len was captured at accept.
          if (bus.pulse_in) begin
            r_cnt <= w_cnt_next;
            if (w_cnt_max) r_ovf <= 1'b1;
          end
          r_rem <= r_rem - 1'b1;
          if (w_last_edge) begin
            r_state <= REPORT;
            r_valid <= 1'b1;
          end
        end
        REPORT: begin
          // Hold result until the consumer takes it; start still ignored.
          if (bus.cnt_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.cnt_valid = r_valid;
  assign bus.cnt_data  = r_cnt;
  assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_pulse_window_counter.sv
// Directed bench for pulse_window_counter. Two instances share stimulus:
// u_dut (COUNT_W=8) is the main target, u_dut4 (COUNT_W=4) covers overflow.
module tb_pulse_window_counter;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  pulse_window_counter_if #(.COUNT_W(8), .WIN_W(16)) bus8 ();
  pulse_window_counter_if #(.COUNT_W(4), .WIN_W(16)) bus4 ();

  pulse_window_counter #(.COUNT_W(8), .WIN_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus8.slave)
  );
  pulse_window_counter #(.COUNT_W(4), .WIN_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PULSE_CNT_SATURATE_EN
  localparam logic [3:0] EXP4_CNT = 4'd15;
`else
  localparam logic [3:0] EXP4_CNT = 4'd4;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic st, input logic [15:0] len, input logic p, input logic rdy);
    bus8.start = st; bus8.window_len = len; bus8.pulse_in = p; bus8.cnt_ready = rdy;
    bus4.start = st; bus4.window_len = len; bus4.pulse_in = p; bus4.cnt_ready = rdy;
  endtask

  // Advance one rising edge, then settle for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drv(1'b0, 16'd0, 1'b0, 1'b0);
    #3;
    chk("rst_busy",  {31'd0, bus8.busy}, 32'd0);
    chk("rst_valid", {31'd0, bus8.cnt_valid}, 32'd0);
    chk("rst_data",  {24'd0, bus8.cnt_data}, 32'd0);
    chk("rst_ovf",   {31'd0, bus8.overflow}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Window 10, pulses on edges 2, 5, 10.
    drv(1'b1, 16'd10, 1'b0, 1'b1);
    step();
    chk("w10_busy_accept", {31'd0, bus8.busy}, 32'd1);
    drv(1'b0, 16'd10, 1'b0, 1'b1);
    for (int e = 1; e <= 10; e++) begin
      bus8.pulse_in = (e == 2 || e == 5 || e == 10);
      bus4.pulse_in = bus8.pulse_in;
      bus8.window_len = 16'd2; // changes after accept must not matter
      step();
      if (e < 10) chk("w10_valid_early", {31'd0, bus8.cnt_valid}, 32'd0);
    end
    drv(1'b0, 16'd0, 1'b0, 1'b1);
    chk("w10_valid", {31'd0, bus8.cnt_valid}, 32'd1);
    chk("w10_data",  {24'd0, bus8.cnt_data}, 32'd3);
    chk("w10_ovf",   {31'd0, bus8.overflow}, 32'd0);
    step();
    chk("w10_valid_after", {31'd0, bus8.cnt_valid}, 32'd0);
    chk("w10_busy_after",  {31'd0, bus8.busy}, 32'd0);
    chk("w10_data_retain", {24'd0, bus8.cnt_data}, 32'd3);
    step();

    // Window 0 with back-pressure; pulse_in high but must be ignored.
    drv(1'b1, 16'd0, 1'b1, 1'b0);
    step();
    drv(1'b0, 16'd0, 1'b1, 1'b0);
    chk("w0_valid", {31'd0, bus8.cnt_valid}, 32'd1);
    chk("w0_data",  {24'd0, bus8.cnt_data}, 32'd0);
    chk("w0_ovf",   {31'd0, bus8.overflow}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("w0_hold_valid", {31'd0, bus8.cnt_valid}, 32'd1);
      chk("w0_hold_data",  {24'd0, bus8.cnt_data}, 32'd0);
    end
    drv(1'b0, 16'd0, 1'b0, 1'b1);
    step();
    chk("w0_xfer_valid", {31'd0, bus8.cnt_valid}, 32'd0);
    chk("w0_xfer_busy",  {31'd0, bus8.busy}, 32'd0);

    // Window 3, extra starts during COUNT and REPORT ignored.
    drv(1'b1, 16'd3, 1'b0, 1'b0);
    step();
    drv(1'b1, 16'd3, 1'b1, 1'b0); step(); // edge 1, pulse
    drv(1'b0, 16'd3, 1'b0, 1'b0); step(); // edge 2
    drv(1'b1, 16'd3, 1'b1, 1'b0); step(); // edge 3, pulse
    chk("w3_valid", {31'd0, bus8.cnt_valid}, 32'd1);
    chk("w3_data",  {24'd0, bus8.cnt_data}, 32'd2);
    drv(1'b1, 16'd3, 1'b0, 1'b0); step();
    chk("w3_hold_valid", {31'd0, bus8.cnt_valid}, 32'd1);
    chk("w3_hold_data",  {24'd0, bus8.cnt_data}, 32'd2);
    drv(1'b1, 16'd3, 1'b0, 1'b1); step(); // transfer with start high
    drv(1'b0, 16'd3, 1'b0, 1'b1);
    chk("w3_xfer_busy", {31'd0, bus8.busy}, 32'd0);
    step();
    chk("w3_start_ignored", {31'd0, bus8.busy}, 32'd0);

    // Window 20, pulse every edge: overflow on the 4-bit instance.
    drv(1'b1, 16'd20, 1'b0, 1'b1);
    step();
    drv(1'b0, 16'd20, 1'b1, 1'b1);
    for (int e = 1; e <= 20; e++) step();
    drv(1'b0, 16'd0, 1'b0, 1'b1);
    chk("w20_valid",  {31'd0, bus4.cnt_valid}, 32'd1);
    chk("w20_data4",  {28'd0, bus4.cnt_data}, {28'd0, EXP4_CNT});
    chk("w20_ovf4",   {31'd0, bus4.overflow}, 32'd1);
    chk("w20_data8",  {24'd0, bus8.cnt_data}, 32'd20);
    chk("w20_ovf8",   {31'd0, bus8.overflow}, 32'd0);
    step();
    chk("w20_ovf4_sticky", {31'd0, bus4.overflow}, 32'd1);

    // Back-to-back: window 2 (two pulses), then window 1 (one pulse).
    drv(1'b1, 16'd2, 1'b0, 1'b1);
    step();
    chk("b2b_ovf4_cleared", {31'd0, bus4.overflow}, 32'd0);
    drv(1'b0, 16'd2, 1'b1, 1'b1);
    step(); step();
    drv(1'b0, 16'd0, 1'b0, 1'b1);
    chk("b2b_first_data", {24'd0, bus8.cnt_data}, 32'd2);
    step(); // transfer
    drv(1'b1, 16'd1, 1'b0, 1'b1);
    step(); // accept
    chk("b2b_second_busy", {31'd0, bus8.busy}, 32'd1);
    drv(1'b0, 16'd0, 1'b1, 1'b1);
    step(); // edge 1
    drv(1'b0, 16'd0, 1'b0, 1'b1);
    chk("b2b_second_valid", {31'd0, bus8.cnt_valid}, 32'd1);
    chk("b2b_second_data",  {24'd0, bus8.cnt_data}, 32'd1);
    step();

    // Reset mid-window: window 8, two pulses counted, reset after edge 4.
    drv(1'b1, 16'd8, 1'b0, 1'b1);
    step();
    drv(1'b0, 16'd8, 1'b1, 1'b1); step(); // edge 1
    drv(1'b0, 16'd8, 1'b0, 1'b1); step(); // edge 2
    drv(1'b0, 16'd8, 1'b1, 1'b1); step(); // edge 3
    drv(1'b0, 16'd8, 1'b0, 1'b1); step(); // edge 4
    chk("rst_mid_busy_before", {31'd0, bus8.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy",  {31'd0, bus8.busy}, 32'd0);
    chk("rst_mid_valid", {31'd0, bus8.cnt_valid}, 32'd0);
    chk("rst_mid_data",  {24'd0, bus8.cnt_data}, 32'd0);
    chk("rst_mid_ovf",   {31'd0, bus8.overflow}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus8.pulse_in = i[0];
      bus4.pulse_in = i[0];
      step();
      chk("rst_post_valid", {31'd0, bus8.cnt_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pulse_window_counter.md
PULSE_WINDOW_COUNTER -- requirements
Module: pulse_window_counter

Interface
REQ-001 The module SHALL have parameter COUNT_W, default 8, giving the width of the event count.
REQ-002 The module SHALL have parameter WIN_W, default 16, giving the width of the window length.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit wide, and is the asynchronous, active-low reset.
REQ-005 Port pulse_in SHALL be an input, 1 bit wide, carrying the pattern-detect flag from the upstream detector; that flag is combinational.
REQ-006 Port start SHALL be an input, 1 bit wide, and is a single-cycle request to open a counting window.
REQ-007 Port window_len SHALL be an input, WIN_W bits wide, giving the window length in clk cycles; it is sampled when start is accepted.
REQ-008 Port busy SHALL be an output, 1 bit wide, high whenever the state is not IDLE.
REQ-009 Port cnt_valid SHALL be an output, 1 bit wide, and is the result-valid signal.
REQ-010 Port cnt_ready SHALL be an input, 1 bit wide, and is the downstream consumer ready.
REQ-011 Port cnt_data SHALL be an output, COUNT_W bits wide, carrying the number of pulse_in events counted in the window.
REQ-012 Port overflow SHALL be an output, 1 bit wide, and is set if the count exceeded 2^COUNT_W-1 during the window.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, COUNT and REPORT; all outputs SHALL be registered.
REQ-014 In IDLE, start=1 SHALL be accepted: window_len latched into the remaining-cycle counter, count and overflow cleared, next state COUNT.
REQ-015 Accepted start with window_len=0 SHALL go directly to REPORT, giving cnt_data=0 and overflow=0.
REQ-016 The window SHALL be the N rising edges after the start-accept edge, where N=window_len; each edge with pulse_in=1 adds exactly one to the count.
REQ-017 At the Nth window edge, the state SHALL go to REPORT and cnt_valid SHALL be 1 on the following cycle; the count SHALL include a pulse sampled at the Nth edge.
REQ-018 A pulse_in that stays high for k consecutive window edges SHALL count as k.
REQ-019 pulse_in SHALL be ignored in IDLE and in REPORT.
REQ-020 start SHALL be ignored while busy=1, including the cycle of the REPORT transfer.
REQ-021 A transfer SHALL occur on an edge where cnt_valid=1 and cnt_ready=1; the next state is IDLE and cnt_valid is 0 on the next cycle.
REQ-022 While cnt_valid=1 and cnt_ready=0, cnt_data and overflow SHALL hold stable; cnt_valid SHALL never drop without a transfer.
REQ-023 cnt_ready SHALL be ignored when cnt_valid=0.
REQ-024 cnt_data and overflow SHALL retain their last reported values in IDLE until the next accepted start clears them.
REQ-025 window_len changes after acceptance SHALL NOT affect the window in progress.

Reset
REQ-026 When rst_n=0, the block SHALL immediately, independent of clk, set state IDLE, busy=0, cnt_valid=0, cnt_data=0, overflow=0 and remaining-cycle counter=0.
REQ-027 A reset asserted mid-COUNT or mid-REPORT SHALL discard the window; after reset release, nothing is reported until a new start.

Configuration
REQ-028 With macro PULSE_CNT_SATURATE_EN defined, a pulse arriving at count 2^COUNT_W-1 SHALL hold the count at 2^COUNT_W-1 and set overflow.
REQ-029 Without PULSE_CNT_SATURATE_EN, a pulse arriving at count 2^COUNT_W-1 SHALL wrap the count to 0 and set overflow.
REQ-030 In both builds, overflow SHALL be sticky until the next accepted start.

Verification
REQ-031 window_len=10, pulse_in high on window edges 2, 5 and 10, cnt_ready=1 -> cnt_valid high for one cycle at window edge+1, cnt_data=3, overflow=0, busy=0 after the transfer.
REQ-032 window_len=0 with start -> REPORT on the next cycle, cnt_data=0; hold cnt_ready=0 for 5 cycles -> cnt_valid and cnt_data stable, then transfer on the cnt_ready=1 edge.
REQ-033 COUNT_W=4, window_len=20, pulse_in high for all 20 edges -> with macro: cnt_data=15, overflow=1; without macro: cnt_data=4, overflow=1.
REQ-034 start pulsed again during COUNT and during REPORT with window_len=3 -> ignored; only the first window is reported.
REQ-035 rst_n asserted at window edge 4 of 8 with 2 pulses counted -> all outputs 0 immediately; no cnt_valid after release until a new start.
REQ-036 Back-to-back windows (start the cycle after the transfer, window_len=1, pulse at edge 1) -> cnt_data=1, with the first window's result unaffected.
